// File: rtl/ext_int_pkg.sv
// Shared register map and service-FSM encoding for the external-interrupt peripheral
// and its Wishbone service master.
package ext_int_pkg;

  localparam int unsigned RegGer        = 0;
  localparam int unsigned RegIerRising  = 1;
  localparam int unsigned RegIerFalling = 2;
  localparam int unsigned RegIsr        = 3;
  localparam int unsigned RegPin        = 4;

  typedef enum logic [2:0] {
    StCfgRise,
    StCfgFall,
    StCfgGer,
    StIdle,
    StRdIsr,
    StClrIsr,
    StPush
  } state_e;

endpackage

// File: rtl/wb_single_master.sv
// Single-transaction Wishbone engine: strobe hold, retry reissue and optional ack timeout.
// Optional feature macro: WB_TIMEOUT_EN (abandon a transaction after TIMEOUT_CYC strobe cycles).
module wb_single_master #(
  parameter int unsigned Aw          = 3,
  parameter int unsigned SELw        = 4,
  parameter int unsigned TAGw        = 3,
  parameter int unsigned Dw          = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [Aw-1:0]   addr_i,
  input  logic [Dw-1:0]   wdata_i,
  output logic            done_o,
  output logic [Dw-1:0]   rdata_o,
  output logic            err_o,
  output logic [Dw-1:0]   m_dat_o,
  output logic [SELw-1:0] m_sel_o,
  output logic [Aw-1:0]   m_addr_o,
  output logic [TAGw-1:0] m_tag_o,
  output logic            m_stb_o,
  output logic            m_cyc_o,
  output logic            m_we_o,
  input  logic [Dw-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  input  logic            m_rty_i
);

  logic          stb_q, retry_q, we_q;
  logic [Aw-1:0] addr_q;
  logic [Dw-1:0] dat_q;
  logic          timeout;
  logic          resp_ack, resp_err, resp_rty;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!stb_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Fires in the TIMEOUT_CYC-th strobe cycle, so stb is high exactly TIMEOUT_CYC cycles.
  assign timeout = stb_q && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // Response priority: ack, then err, then rty; a timeout yields to a same-cycle retry.
  assign resp_ack = stb_q & m_ack_i;
  assign resp_err = stb_q & ~m_ack_i & (m_err_i | (timeout & ~m_rty_i));
  assign resp_rty = stb_q & ~m_ack_i & ~m_err_i & m_rty_i;

  assign done_o  = resp_ack | resp_err;
  assign err_o   = resp_err;
  assign rdata_o = m_dat_i;

  // A new request is only accepted with stb low, which guarantees the idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stb_q   <= 1'b0;
      retry_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
    end else if (stb_q) begin
      if (resp_ack || resp_err || resp_rty) begin
        stb_q   <= 1'b0;
        retry_q <= resp_rty;
      end
    end else if (retry_q) begin
      stb_q   <= 1'b1;
      retry_q <= 1'b0;
    end else if (req_i) begin
      stb_q  <= 1'b1;
      we_q   <= we_i;
      addr_q <= addr_i;
      dat_q  <= wdata_i;
    end
  end

  assign m_stb_o  = stb_q;
  assign m_cyc_o  = stb_q;
  assign m_we_o   = we_q;
  assign m_addr_o = addr_q;
  assign m_dat_o  = dat_q;
  assign m_sel_o  = '1;
  assign m_tag_o  = '0;

endmodule

// File: rtl/ext_int_service_master.sv
// Service FSM: configures the interrupt peripheral, then reads/clears ISR and pushes events.
// Optional feature macro: WB_TIMEOUT_EN (bus ack timeout inside wb_single_master).
module ext_int_service_master
  import ext_int_pkg::*;
#(
  parameter int unsigned EXT_INT_NUM = 3,
  parameter int unsigned Aw          = 3,
  parameter int unsigned SELw        = 4,
  parameter int unsigned TAGw        = 3,
  parameter int unsigned Dw          = 32,
  parameter logic [EXT_INT_NUM-1:0] IER_RISE_INIT = '1,
  parameter logic [EXT_INT_NUM-1:0] IER_FALL_INIT = '0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [Dw-1:0]          m_dat_o,
  output logic [SELw-1:0]        m_sel_o,
  output logic [Aw-1:0]          m_addr_o,
  output logic [TAGw-1:0]        m_tag_o,
  output logic                   m_stb_o,
  output logic                   m_cyc_o,
  output logic                   m_we_o,
  input  logic [Dw-1:0]          m_dat_i,
  input  logic                   m_ack_i,
  input  logic                   m_err_i,
  input  logic                   m_rty_i,
  input  logic                   int_i,
  output logic [EXT_INT_NUM-1:0] evt_vec_o,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic                   init_done_o,
  output logic                   bus_err_o
);

  state_e                 state_q;
  logic [EXT_INT_NUM-1:0] vec_q, evt_vec_q, rd_vec;
  logic                   evt_valid_q, init_done_q, bus_err_q;

  logic          req, we, done, err;
  logic [Aw-1:0] addr;
  logic [Dw-1:0] wdata, rdata;

  logic unused_rdata;
  assign unused_rdata = ^rdata;
  assign rd_vec = rdata[EXT_INT_NUM-1:0];

  always_comb begin
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    unique case (state_q)
      StCfgRise: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = Aw'(RegIerRising);
        wdata = Dw'(IER_RISE_INIT);
      end
      StCfgFall: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = Aw'(RegIerFalling);
        wdata = Dw'(IER_FALL_INIT);
      end
      // Global enable goes last so no edge is captured while half-configured.
      StCfgGer: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = Aw'(RegGer);
        wdata = Dw'(1);
      end
      StIdle: begin
        req  = int_i;
        addr = Aw'(RegIsr);
      end
      StClrIsr: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = Aw'(RegIsr);
        wdata = Dw'(vec_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StCfgRise;
      vec_q       <= '0;
      evt_vec_q   <= '0;
      evt_valid_q <= 1'b0;
      init_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if (err) bus_err_q <= 1'b1;
      unique case (state_q)
        StCfgRise: if (done) state_q <= StCfgFall;
        StCfgFall: if (done) state_q <= StCfgGer;
        StCfgGer: begin
          if (done) begin
            init_done_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StIdle: if (int_i) state_q <= StRdIsr;
        StRdIsr: begin
          if (done) begin
            if (err || (rd_vec == '0)) begin
              state_q <= StIdle;
            end else begin
              vec_q   <= rd_vec;
              state_q <= StClrIsr;
            end
          end
        end
        // The vector is pushed even if the clear write errored.
        StClrIsr: begin
          if (done) begin
            evt_valid_q <= 1'b1;
            evt_vec_q   <= vec_q;
            state_q     <= StPush;
          end
        end
        StPush: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StCfgRise;
      endcase
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_vec_o   = evt_vec_q;
  assign init_done_o = init_done_q;
  assign bus_err_o   = bus_err_q;

  wb_single_master #(
    .Aw          (Aw),
    .SELw        (SELw),
    .TAGw        (TAGw),
    .Dw          (Dw),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .done_o   (done),
    .rdata_o  (rdata),
    .err_o    (err),
    .m_dat_o  (m_dat_o),
    .m_sel_o  (m_sel_o),
    .m_addr_o (m_addr_o),
    .m_tag_o  (m_tag_o),
    .m_stb_o  (m_stb_o),
    .m_cyc_o  (m_cyc_o),
    .m_we_o   (m_we_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i),
    .m_err_i  (m_err_i),
    .m_rty_i  (m_rty_i)
  );

endmodule
